// File: rtl/module_hamming_ctrl.sv
// ============================================================================
// Module   : module_hamming_ctrl
// Purpose  : Sequencer for the Hamming(7,4) correction path. Accepts a
//            received codeword over a valid/ready handshake and computes its
//            3-bit syndrome. It drives an external combinational corrector
//            with the codeword and syndrome, then registers the corrected
//            codeword, its decoded data nibble and the error status.
//
// Ports    : clk, rst_n        clock (rising edge), async active-low reset
//            in_valid/in_ready  codeword handshake, in_code[6:0] codeword
//                               laid out as [i3,i2,i1,c2,i0,c1,c0]
//            corr_datos[6:0]    codeword to the corrector
//            corr_sindrome[2:0] syndrome [p2,p1,p0] to the corrector
//            corr_data[6:0]     corrected codeword from the corrector
//            out_valid/out_ready result handshake
//            out_code[6:0]      corrected codeword
//            out_data[3:0]      decoded data {bit6,bit5,bit4,bit2}
//            out_err            syndrome of this word was nonzero
//            out_sindrome[2:0]  syndrome of this word
//            stats_clr          synchronous clear of err_count
//            err_count[CNT_W-1:0] saturating count of corrected words
//
// Options  : HAMMING_STATS_EN  when defined, builds the error counter;
//            otherwise err_count is tied to zero and stats_clr is ignored.
//
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module module_hamming_ctrl #(
  parameter int CNT_W = 16   // error counter width, 2 or more
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  output logic [2:0]       corr_sindrome,
  output logic [6:0]       corr_datos,
  input  logic [6:0]       corr_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_code,
  output logic [3:0]       out_data,
  output logic             out_err,
  output logic [2:0]       out_sindrome,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYND = 2'd1,
    CORR = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t     r_state;
  logic [6:0] r_code;
  logic [2:0] r_syn;
  logic       r_in_ready;
  logic       r_out_valid;
  logic [6:0] r_out_code;
  logic [3:0] r_out_data;
  logic       r_out_err;
  logic [2:0] r_out_sindrome;

  logic [2:0] w_syn;

  // Each syndrome bit covers the codeword positions (1-based) whose index
  // has that bit set, so a single error yields its own position.
  assign w_syn[0] = r_code[0] ^ r_code[2] ^ r_code[4] ^ r_code[6];
  assign w_syn[1] = r_code[1] ^ r_code[2] ^ r_code[5] ^ r_code[6];
  assign w_syn[2] = r_code[3] ^ r_code[4] ^ r_code[5] ^ r_code[6];

  // The corrector sees only registered values, so its input never glitches.
  assign corr_datos    = r_code;
  assign corr_sindrome = r_syn;

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_code     = r_out_code;
  assign out_data     = r_out_data;
  assign out_err      = r_out_err;
  assign out_sindrome = r_out_sindrome;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_code         <= 7'd0;
      r_syn          <= 3'd0;
      r_in_ready     <= 1'b1;
      r_out_valid    <= 1'b0;
      r_out_code     <= 7'd0;
      r_out_data     <= 4'd0;
      r_out_err      <= 1'b0;
      r_out_sindrome <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_code     <= in_code;
            r_in_ready <= 1'b0;
            r_state    <= SYND;
          end
        end
        SYND: begin
          r_syn   <= w_syn;
          r_state <= CORR;
        end
        CORR: begin
          // Corrector output has settled a full cycle after r_syn loaded.
          r_out_code     <= corr_data;
          r_out_data     <= {corr_data[6], corr_data[5], corr_data[4], corr_data[2]};
          r_out_err      <= |r_syn;
          r_out_sindrome <= r_syn;
          r_out_valid    <= 1'b1;
          r_state        <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef HAMMING_STATS_EN
  logic [CNT_W-1:0] r_err_count;

  // Clear has priority over a same-edge increment; count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (stats_clr) begin
      r_err_count <= '0;
    end else if ((r_state == CORR) && (|r_syn) && !(&r_err_count)) begin
      r_err_count <= r_err_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign err_count = r_err_count;
`else
  logic unused_stats_clr;

  assign unused_stats_clr = stats_clr;
  assign err_count        = '0;
`endif

endmodule

`default_nettype wire
